// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the memory stage
package mips_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int REG_IDX_W       = 5;

endpackage

// File: rtl/writeback_reg.sv
// rtl/writeback_reg.sv - MEM/WB pipeline register with bubble/load select
module writeback_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 d_regwrite,
    input  logic                 d_memtoreg,
    input  logic [DATA_W-1:0]    d_readdata,
    input  logic [DATA_W-1:0]    d_aluout,
    input  logic [REG_IDX_W-1:0] d_writereg,
    input  logic                 d_misalign,
    input  logic                 d_buserr,
    output logic                 q_regwrite,
    output logic                 q_memtoreg,
    output logic [DATA_W-1:0]    q_readdata,
    output logic [DATA_W-1:0]    q_aluout,
    output logic [REG_IDX_W-1:0] q_writereg,
    output logic                 q_misalign,
    output logic                 q_buserr
);

    // Capture the presented instruction when load=1, otherwise insert an all-zero bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_regwrite <= 1'b0;
            q_memtoreg <= 1'b0;
            q_readdata <= '0;
            q_aluout   <= '0;
            q_writereg <= '0;
            q_misalign <= 1'b0;
            q_buserr   <= 1'b0;
        end else if (load) begin
            q_regwrite <= d_regwrite;
            q_memtoreg <= d_memtoreg;
            q_readdata <= d_readdata;
            q_aluout   <= d_aluout;
            q_writereg <= d_writereg;
            q_misalign <= d_misalign;
            q_buserr   <= d_buserr;
        end else begin
            q_regwrite <= 1'b0;
            q_memtoreg <= 1'b0;
            q_readdata <= '0;
            q_aluout   <= '0;
            q_writereg <= '0;
            q_misalign <= 1'b0;
            q_buserr   <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage: bus req/ack sequencing, stall and MEM/WB update
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RegWriteM,
    input  logic                 MemtoRegM,
    input  logic                 MemWriteM,
    input  logic [DATA_W-1:0]    AluOutM,
    input  logic [DATA_W-1:0]    WriteDataM,
    input  logic [REG_IDX_W-1:0] WriteRegM,
    output logic                 StallM,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_ack,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 RegWriteW,
    output logic                 MemtoRegW,
    output logic [DATA_W-1:0]    ReadDataW,
    output logic [DATA_W-1:0]    AluOutW,
    output logic [REG_IDX_W-1:0] WriteRegW,
    output logic                 MisalignW,
    output logic                 BusErrW
);

    // Last BUSY cycle index before the access is abandoned as a bus error.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t              state, state_n;
    logic [7:0]          cnt, cnt_n;
    logic                req_n, we_n;
    logic [DATA_W-1:0]   addr_n, wdata_n;

    logic                access, aligned;
    logic                wb_load;
    logic                wb_regwrite, wb_memtoreg, wb_misalign, wb_buserr;
    logic [DATA_W-1:0]   wb_readdata;

    assign access  = MemtoRegM | MemWriteM;
    assign aligned = (AluOutM[1:0] == 2'b00);

    // State, timeout counter and bus-side registers; reset abandons any outstanding access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
        end
    end

    // Next-state, stall and MEM/WB data selection; a store wins when load and store are both set.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        req_n       = mem_req;
        we_n        = mem_we;
        addr_n      = mem_addr;
        wdata_n     = mem_wdata;
        StallM      = 1'b0;
        wb_load     = 1'b0;
        wb_regwrite = RegWriteM;
        wb_memtoreg = MemtoRegM;
        wb_readdata = '0;
        wb_misalign = 1'b0;
        wb_buserr   = 1'b0;
        case (state)
            IDLE: begin
                if (!access) begin
                    wb_load = 1'b1;
                end else if (!aligned) begin
                    wb_load     = 1'b1;
                    wb_regwrite = 1'b0;
                    wb_misalign = 1'b1;
                end else begin
                    StallM  = 1'b1;
                    state_n = BUSY;
                    req_n   = 1'b1;
                    we_n    = MemWriteM;
                    addr_n  = AluOutM;
                    wdata_n = WriteDataM;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_n     = IDLE;
                    req_n       = 1'b0;
                    wb_load     = 1'b1;
                    wb_readdata = mem_we ? '0 : mem_rdata;
                end else if (cnt == LAST_CNT) begin
                    state_n     = IDLE;
                    req_n       = 1'b0;
                    wb_load     = 1'b1;
                    wb_regwrite = 1'b0;
                    wb_buserr   = 1'b1;
                end else begin
                    StallM = 1'b1;
                    cnt_n  = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    writeback_reg #(.DATA_W(DATA_W)) u_wb (
        .clk        (clk),
        .rst        (rst),
        .load       (wb_load),
        .d_regwrite (wb_regwrite),
        .d_memtoreg (wb_memtoreg),
        .d_readdata (wb_readdata),
        .d_aluout   (AluOutM),
        .d_writereg (WriteRegM),
        .d_misalign (wb_misalign),
        .d_buserr   (wb_buserr),
        .q_regwrite (RegWriteW),
        .q_memtoreg (MemtoRegW),
        .q_readdata (ReadDataW),
        .q_aluout   (AluOutW),
        .q_writereg (WriteRegW),
        .q_misalign (MisalignW),
        .q_buserr   (BusErrW)
    );

endmodule
